// File: rtl/accumulator_16bit_pkg.sv
// Shared widths, limits and FSM state encoding for the burst accumulator.
package accumulator_16bit_pkg;

    localparam int DATA_W = 16;
    localparam int CNT_W  = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/accumulator_16bit_if.sv
// Operand stream in, burst result out; the accumulator is the slave side.
interface accumulator_16bit_if;
    import accumulator_16bit_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_sum;
    logic              out_ovf;
    logic [CNT_W-1:0]  out_count;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf, out_count
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_ovf, out_count
    );

endinterface

// File: rtl/accumulator_16bit_adder.sv
// 16-bit carry-skip adder: four 4-bit ripple blocks, each bypassed when all its bits propagate.
module carry_skip_adder_16bit
    import accumulator_16bit_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cin,
    output logic [DATA_W-1:0] s,
    output logic              cout
);

    localparam int BLK  = 4;
    localparam int NBLK = DATA_W / BLK;

    logic [NBLK:0] c_blk;

    assign c_blk[0] = cin;

    for (genvar g = 0; g < NBLK; g++) begin : g_blk
        logic [BLK:0]   c;
        logic [BLK-1:0] p;

        assign c[0] = c_blk[g];

        for (genvar i = 0; i < BLK; i++) begin : g_bit
            assign p[i]           = a[g*BLK+i] ^ b[g*BLK+i];
            assign s[g*BLK+i]     = p[i] ^ c[i];
            assign c[i+1]         = (a[g*BLK+i] & b[g*BLK+i]) | (p[i] & c[i]);
        end

        // A fully propagating block passes its carry-in straight through.
        assign c_blk[g+1] = (&p) ? c_blk[g] : c[BLK];
    end

    assign cout = c_blk[NBLK];

endmodule

// File: rtl/accumulator_16bit.sv
// Burst accumulator: sums operands until in_last, then holds the result until it is taken.
module accumulator_16bit
    import accumulator_16bit_pkg::*;
#(
    parameter bit SATURATE = 1'b0
)
(
    input  logic                clk,
    input  logic                rst_n,
    accumulator_16bit_if.slave  bus
);

    state_t            state;
    logic [DATA_W-1:0] acc;
    logic              ovf;
    logic [CNT_W-1:0]  count;

    logic [DATA_W-1:0] add_a;
    logic [DATA_W-1:0] add_s;
    logic              add_cout;
    logic              accept;
    logic              next_ovf;

    // The first operand of a burst is added to zero so every load goes through the adder.
    assign add_a    = (state == ST_IDLE) ? '0 : acc;
    assign accept   = bus.in_valid && (state != ST_HOLD);
    assign next_ovf = ((state == ST_ACC) && ovf) | add_cout;

    carry_skip_adder_16bit u_adder (
        .a    (add_a),
        .b    (bus.in_data),
        .cin  (1'b0),
        .s    (add_s),
        .cout (add_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            acc   <= '0;
            ovf   <= 1'b0;
            count <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_ACC: begin
                    if (accept) begin
                        acc   <= (SATURATE && next_ovf) ? '1 : add_s;
                        ovf   <= next_ovf;
                        if (state == ST_IDLE)
                            count <= CNT_W'(1);
                        else if (count != CNT_MAX)
                            count <= count + 1'b1;
                        state <= bus.in_last ? ST_HOLD : ST_ACC;
                    end
                end
                ST_HOLD: begin
                    if (bus.out_ready)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state != ST_HOLD);
    assign bus.out_valid = (state == ST_HOLD);
    assign bus.out_sum   = acc;
    assign bus.out_ovf   = ovf;
    assign bus.out_count = count;

endmodule

// File: doc/accumulator_16bit.md
ACCUMULATOR_16BIT -- requirements
Module: accumulator_16bit

Interface
REQ-001 Parameter SATURATE, default 0; 1 = clamp accumulator at 16'hFFFF on overflow, 0 = wrap modulo 2^16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  upstream operand valid.
REQ-005 in_ready  output  1  block can accept an operand this cycle.
REQ-006 in_data  input  16  unsigned operand.
REQ-007 in_last  input  1  marks final operand of a burst; qualified by in_valid.
REQ-008 out_valid  output  1  burst result available.
REQ-009 out_ready  input  1  downstream accepts result.
REQ-010 out_sum  output  16  accumulated sum (wrapped or saturated per SATURATE).
REQ-011 out_ovf  output  1  sticky: at least one addition in the burst produced carry-out.
REQ-012 out_count  output  8  operands accepted in the burst, saturating at 255.

Function
REQ-013 States: IDLE, ACC, HOLD; encoding free.
REQ-014 Operand accepted when in_valid && in_ready; in_ready = 1 in IDLE and ACC, 0 in HOLD.
REQ-015 Addition: next_acc = acc + in_data with cin = 0, performed by one carry_skip_adder_16bit instance; no other adder on the datapath.
REQ-016 On accept in IDLE: acc loads 0 + in_data (through the adder), ovf cleared then OR'd with cout, count = 1.
REQ-017 On accept in ACC: acc <= adder sum, ovf <= ovf | cout, count <= min(count+1, 255).
REQ-018 SATURATE=1: if cout=1 or ovf already set, acc <= 16'hFFFF; SATURATE=0: acc <= adder sum unchanged.
REQ-019 Transitions: IDLE->ACC on accept with in_last=0; IDLE->HOLD on accept with in_last=1; ACC->HOLD on accept with in_last=1; ACC stays otherwise; HOLD->IDLE on out_ready=1.
REQ-020 out_valid = 1 exactly in HOLD; out_sum/out_ovf/out_count stable while out_valid=1 and out_ready=0.
REQ-021 Latency: result visible on out_* the cycle after the in_last operand is accepted.
REQ-022 Result handshake completes in the cycle out_valid && out_ready; next cycle state IDLE, in_ready=1; no operand accepted in that same cycle (no bypass).
REQ-023 in_data/in_last ignored when in_valid=0; in_valid=1 in HOLD causes no state change.
REQ-024 Single-operand burst (first operand with in_last=1) yields out_sum=in_data, out_ovf=0, out_count=1.
REQ-025 Outside HOLD, out_sum/out_ovf/out_count show current running values (not qualified).

Reset
REQ-026 rst_n low forces state IDLE, acc=0, ovf=0, count=0, out_valid=0, in_ready=1 immediately, regardless of clk.
REQ-027 Reset mid-burst or in HOLD discards partial/unconsumed result; no output after release until a new burst completes.
REQ-028 First operand accepted on first rising edge with rst_n high and in_valid=1.

Structure
REQ-029 Shared package holds state encoding constants, DATA_W=16, CNT_W=8, CNT_MAX=255.
REQ-030 One sub-module: carry_skip_adder_16bit (ports a, b, cin, s, cout), instantiated once; control FSM and registers in accumulator_16bit.

Verification
REQ-031 Burst 16'h0001, 16'h0002, 16'h0003(last), out_ready=1 -> out_sum=16'h0006, out_ovf=0, out_count=3, out_valid high one cycle.
REQ-032 SATURATE=0, burst 16'hFFFF, 16'h0002(last) -> out_sum=16'h0001, out_ovf=1, out_count=2.
REQ-033 SATURATE=1, burst 16'hFFF0, 16'h0020, 16'h0001(last) -> out_sum=16'hFFFF, out_ovf=1, out_count=3.
REQ-034 HOLD with out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, outputs unchanged; out_ready=1 -> IDLE next cycle, held input then accepted.
REQ-035 300 operands of 16'h0000 then last -> out_count=255, out_sum=0, out_ovf=0.
REQ-036 rst_n low between clk edges after 2 operands -> out_valid=0, in_ready=1 at once; new burst 16'h0005(last) -> out_sum=16'h0005, out_count=1.
